// File: rtl/rob_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : rob_cmd_issuer
// Brief    : Drains one ROB row into a local buffer and issues ACT/RD/WR/PRE.
// Revision : 1.0
// ============================================================================
module rob_cmd_issuer #(
    parameter int ROW_W   = 11,
    parameter int COL_W   = 8,
    parameter int ITEM_W  = 24,
    parameter int DEPTH   = 8,
    parameter int T_RCD   = 3,
    parameter int T_CCD   = 2,
    parameter int T_PRE   = 4,
    parameter int T_RP    = 3,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iRowReq,
    input  logic [ROW_W-1:0]  iRowAddr,
    output logic              oRowAck,
    output logic              oROB_Rd,
    output logic [ROW_W-1:0]  oROB_Row,
    input  logic              iROB_ItemValid,
    input  logic [ITEM_W-1:0] iROB_Item,
    input  logic              iROB_ItemEnd,
    output logic              oCmdValid,
    input  logic              iCmdReady,
    output logic [2:0]        oCmd,
    output logic [ROW_W-1:0]  oCmdRow,
    output logic [COL_W-1:0]  oCmdCol,
    output logic [1:0]        oCmdSize,
    output logic              oBusy,
    output logic              oTimeout,
    output logic              oOverflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int c_LOS_BIT  = COL_W + 1;
    localparam int c_SIZE_LSB = COL_W + 2;

    localparam logic [2:0] c_CMD_NOP = 3'd0;
    localparam logic [2:0] c_CMD_ACT = 3'd1;
    localparam logic [2:0] c_CMD_RD  = 3'd2;
    localparam logic [2:0] c_CMD_WR  = 3'd3;
    localparam logic [2:0] c_CMD_PRE = 3'd4;

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_COLLECT  = 4'd1;
    localparam logic [3:0] c_ACT      = 4'd2;
    localparam logic [3:0] c_WAIT_RCD = 4'd3;
    localparam logic [3:0] c_COL      = 4'd4;
    localparam logic [3:0] c_WAIT_CCD = 4'd5;
    localparam logic [3:0] c_WAIT_PRE = 4'd6;
    localparam logic [3:0] c_PRE      = 4'd7;
    localparam logic [3:0] c_WAIT_RP  = 4'd8;

    logic [3:0]       r_state;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] r_robRow;
    logic             r_rowAck;
    logic             r_robRd;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rdPtr;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_cnt;
    logic             r_timeout;
    logic             r_overflow;

    logic [COL_W-1:0] r_col  [DEPTH];
    logic [1:0]       r_size [DEPTH];
    logic             r_los  [DEPTH];

    logic w_capture;
    logic w_store;
    logic w_unused;

    assign w_capture = iROB_ItemValid && iROB_Item[0];
    assign w_store   = w_capture && (r_count < CNT_W'(DEPTH));
    assign w_unused  = &{1'b0, iROB_Item[ITEM_W-1:COL_W+4]};

    assign oRowAck   = r_rowAck;
    assign oROB_Rd   = r_robRd;
    assign oROB_Row  = r_robRow;
    assign oBusy     = (r_state != c_IDLE);
    assign oTimeout  = r_timeout;
    assign oOverflow = r_overflow;

    // Command outputs depend only on registered state, so they stay stable under backpressure.
    always_comb begin
        oCmdValid = 1'b0;
        oCmd      = c_CMD_NOP;
        oCmdRow   = '0;
        oCmdCol   = '0;
        oCmdSize  = '0;
        case (r_state)
            c_ACT: begin
                oCmdValid = 1'b1;
                oCmd      = c_CMD_ACT;
                oCmdRow   = r_row;
            end
            c_COL: begin
                oCmdValid = 1'b1;
                oCmd      = r_los[r_rdPtr] ? c_CMD_WR : c_CMD_RD;
                oCmdRow   = r_row;
                oCmdCol   = r_col[r_rdPtr];
                oCmdSize  = r_size[r_rdPtr];
            end
            c_PRE: begin
                oCmdValid = 1'b1;
                oCmd      = c_CMD_PRE;
                oCmdRow   = r_row;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == c_COLLECT && w_store) begin
            r_col[r_count[PTR_W-1:0]]  <= iROB_Item[COL_W:1];
            r_los[r_count[PTR_W-1:0]]  <= iROB_Item[c_LOS_BIT];
            r_size[r_count[PTR_W-1:0]] <= iROB_Item[c_SIZE_LSB +: 2];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_row      <= '0;
            r_robRow   <= '0;
            r_rowAck   <= 1'b0;
            r_robRd    <= 1'b0;
            r_count    <= '0;
            r_rdPtr    <= '0;
            r_tmo      <= '0;
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rowAck <= 1'b0;
            r_robRd  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (iRowReq) begin
                        r_rowAck <= 1'b1;
                        r_robRd  <= 1'b1;
                        r_robRow <= iRowAddr;
                        r_row    <= iRowAddr;
                        r_count  <= '0;
                        r_rdPtr  <= '0;
                        r_tmo    <= '0;
                        r_state  <= c_COLLECT;
                    end
                end
                c_COLLECT: begin
                    if (w_store) begin
                        r_count <= r_count + CNT_W'(1);
                    end else if (w_capture) begin
                        r_overflow <= 1'b1;
                    end
                    // An item arriving with the end marker has already been counted above.
                    if (iROB_ItemEnd) begin
                        r_state <= (r_count == '0 && !w_store) ? c_IDLE : c_ACT;
                    end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_count   <= '0;
                        r_state   <= c_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                c_ACT: begin
                    if (iCmdReady) begin
                        r_cnt   <= 8'(T_RCD);
                        r_state <= (T_RCD == 0) ? c_COL : c_WAIT_RCD;
                    end
                end
                c_WAIT_RCD: begin
                    if (r_cnt <= 8'd1) r_state <= c_COL;
                    else r_cnt <= r_cnt - 8'd1;
                end
                c_COL: begin
                    if (iCmdReady) begin
                        r_rdPtr <= r_rdPtr + PTR_W'(1);
                        r_count <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            r_cnt   <= 8'(T_PRE);
                            r_state <= (T_PRE == 0) ? c_PRE : c_WAIT_PRE;
                        end else begin
                            r_cnt   <= 8'(T_CCD);
                            r_state <= (T_CCD == 0) ? c_COL : c_WAIT_CCD;
                        end
                    end
                end
                c_WAIT_CCD: begin
                    if (r_cnt <= 8'd1) r_state <= c_COL;
                    else r_cnt <= r_cnt - 8'd1;
                end
                c_WAIT_PRE: begin
                    if (r_cnt <= 8'd1) r_state <= c_PRE;
                    else r_cnt <= r_cnt - 8'd1;
                end
                c_PRE: begin
                    if (iCmdReady) begin
                        r_cnt   <= 8'(T_RP);
                        r_state <= (T_RP == 0) ? c_IDLE : c_WAIT_RP;
                    end
                end
                c_WAIT_RP: begin
                    if (r_cnt <= 8'd1) r_state <= c_IDLE;
                    else r_cnt <= r_cnt - 8'd1;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_cmd_issuer
// Brief    : Scoreboard bench for rob_cmd_issuer with a row-level command model.
// Revision : 1.0
// ============================================================================
module tb_rob_cmd_issuer;

    localparam int ROW_W = 11, COL_W = 8, ITEM_W = 24, DEPTH = 8;
    localparam int T_RCD = 3, T_CCD = 2, T_PRE = 4, T_RP = 3, TIMEOUT = 32;
    localparam logic [2:0] c_ACT = 3'd1, c_RD = 3'd2, c_WR = 3'd3, c_PRE = 3'd4;

    typedef struct {
        logic [2:0]       cmd;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [1:0]       size;
        int               gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic iRowReq;
    logic [ROW_W-1:0] iRowAddr;
    logic oRowAck, oROB_Rd;
    logic [ROW_W-1:0] oROB_Row;
    logic iROB_ItemValid;
    logic [ITEM_W-1:0] iROB_Item;
    logic iROB_ItemEnd;
    logic oCmdValid;
    logic iCmdReady;
    logic [2:0] oCmd;
    logic [ROW_W-1:0] oCmdRow;
    logic [COL_W-1:0] oCmdCol;
    logic [1:0] oCmdSize;
    logic oBusy, oTimeout, oOverflow;

    always #5 clk = ~clk;

    rob_cmd_issuer #(
        .ROW_W(ROW_W), .COL_W(COL_W), .ITEM_W(ITEM_W), .DEPTH(DEPTH),
        .T_RCD(T_RCD), .T_CCD(T_CCD), .T_PRE(T_PRE), .T_RP(T_RP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .iRowReq(iRowReq), .iRowAddr(iRowAddr), .oRowAck(oRowAck),
        .oROB_Rd(oROB_Rd), .oROB_Row(oROB_Row),
        .iROB_ItemValid(iROB_ItemValid), .iROB_Item(iROB_Item), .iROB_ItemEnd(iROB_ItemEnd),
        .oCmdValid(oCmdValid), .iCmdReady(iCmdReady), .oCmd(oCmd),
        .oCmdRow(oCmdRow), .oCmdCol(oCmdCol), .oCmdSize(oCmdSize),
        .oBusy(oBusy), .oTimeout(oTimeout), .oOverflow(oOverflow)
    );

    int nChecks = 0;
    int nPass   = 0;
    exp_t sb[$];
    logic [ITEM_W-1:0] itemQ[$];
    logic expT = 1'b0;
    logic expO = 1'b0;
    int readyMode = 0;
    int st1 = 0, st2 = 0;
    int nFire = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [ITEM_W-1:0] mkItem(input logic [7:0] col, input logic los,
                                                  input logic [1:0] sz, input logic v);
        logic [11:0] hi;
        hi = 12'($urandom);
        return {hi, sz, los, col, v};
    endfunction

    // Backpressure: always ready, random, or a fixed stall on ACT and the second column command.
    always @(posedge clk) begin
        #1;
        if (readyMode == 0) iCmdReady = 1'b1;
        else if (readyMode == 1) iCmdReady = ($urandom_range(0, 3) != 0);
        else if (oCmdValid && nFire == 0 && st1 < 5) begin iCmdReady = 1'b0; st1++; end
        else if (oCmdValid && nFire == 2 && st2 < 2) begin iCmdReady = 1'b0; st2++; end
        else iCmdReady = 1'b1;
    end

    logic [23:0] held;
    bit   inCmd = 0, haveLast = 0;
    int   gapCnt = 0, rpCnt = -1;
    exp_t e;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            inCmd = 0; haveLast = 0; gapCnt = 0; rpCnt = -1; nFire = 0;
        end else begin
            if (rpCnt >= 0) begin
                if (oBusy) rpCnt++;
                else begin
                    chk("rp_busy_cycles", 64'(rpCnt), 64'(T_RP));
                    rpCnt = -1; haveLast = 0;
                end
            end
            if (oCmdValid) begin
                if (!inCmd) begin
                    if (sb.size() == 0) chk("unexpected_cmd", 64'(oCmd), 64'd0);
                    else if (haveLast && sb[0].gap >= 0) chk("gap", 64'(gapCnt), 64'(sb[0].gap));
                end else begin
                    chk("hold_stable", {oCmd, oCmdRow, oCmdCol, oCmdSize}, held);
                end
                held  = {oCmd, oCmdRow, oCmdCol, oCmdSize};
                inCmd = 1;
                if (iCmdReady) begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("cmd", {oCmd, oCmdRow, oCmdCol, oCmdSize}, {e.cmd, e.row, e.col, e.size});
                        if (e.cmd == c_PRE) begin rpCnt = 0; nFire = 0; end
                        else nFire++;
                    end
                    inCmd = 0; gapCnt = 0; haveLast = 1;
                end
            end else if (haveLast) begin
                gapCnt++;
            end
        end
    end

    // Reference: first DEPTH valid items in arrival order, framed by ACT and PRE.
    task automatic pushModel(input logic [ROW_W-1:0] row);
        exp_t x;
        int nv;
        nv = 0;
        foreach (itemQ[i]) begin
            if (itemQ[i][0]) begin
                if (nv < DEPTH) begin
                    if (nv == 0) begin
                        x.cmd = c_ACT; x.row = row; x.col = '0; x.size = '0; x.gap = -1;
                        sb.push_back(x);
                    end
                    x.cmd  = itemQ[i][9] ? c_WR : c_RD;
                    x.row  = row;
                    x.col  = itemQ[i][8:1];
                    x.size = itemQ[i][11:10];
                    x.gap  = (nv == 0) ? T_RCD : T_CCD;
                    sb.push_back(x);
                end
                nv++;
            end
        end
        if (nv > 0) begin
            x.cmd = c_PRE; x.row = row; x.col = '0; x.size = '0; x.gap = T_PRE;
            sb.push_back(x);
        end
        if (nv > DEPTH) expO = 1'b1;
    endtask

    task automatic reqRow(input logic [ROW_W-1:0] row);
        @(posedge clk); #1 iRowReq = 1'b1; iRowAddr = row;
        @(posedge clk); #1 iRowReq = 1'b0; iRowAddr = ROW_W'($urandom);
        @(negedge clk);
        chk("row_ack", {oRowAck, oROB_Rd, oROB_Row}, {2'b11, row});
    endtask

    task automatic driveItems(input bit bubbles);
        int cyc;
        cyc = 0;
        for (int i = 0; i < itemQ.size(); i++) begin
            if (bubbles && cyc < 12 && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1 iROB_ItemValid = 1'b0; iROB_ItemEnd = 1'b0;
                cyc++;
            end
            @(posedge clk); #1;
            iROB_ItemValid = 1'b1;
            iROB_Item      = itemQ[i];
            iROB_ItemEnd   = (i == itemQ.size() - 1);
            cyc++;
            if (i == 0) begin
                @(negedge clk);
                chk("rob_pulse_width", {oRowAck, oROB_Rd}, 2'b00);
            end
        end
        @(posedge clk); #1 iROB_ItemValid = 1'b0; iROB_ItemEnd = 1'b0; iROB_Item = '0;
    endtask

    task automatic runRow(input logic [ROW_W-1:0] row, input bit bubbles);
        reqRow(row);
        pushModel(row);
        driveItems(bubbles);
    endtask

    task automatic finishRow();
        int k;
        k = 0;
        while (oBusy && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 64'(k < 500), 64'd1);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("sticky_flags", {oTimeout, oOverflow}, {expT, expO});
    endtask

    task automatic threeItems();
        itemQ.delete();
        itemQ.push_back(mkItem(8'h10, 1'b0, 2'd1, 1'b1));
        itemQ.push_back(mkItem(8'h14, 1'b1, 2'd2, 1'b1));
        itemQ.push_back(mkItem(8'h18, 1'b0, 2'd3, 1'b1));
    endtask

    initial begin
        int k, nv, ni;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nv, ni;
        reset = 1'b1; iRowReq = 1'b0; iRowAddr = '0;
        iROB_ItemValid = 1'b0; iROB_Item = '0; iROB_ItemEnd = 1'b0; iCmdReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {oRowAck, oROB_Rd, oROB_Row, oCmdValid, oCmd, oCmdRow, oCmdCol,
                              oCmdSize, oBusy, oTimeout, oOverflow}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        readyMode = 0;
        threeItems();
        runRow(11'h12A, 1'b0);
        finishRow();

        readyMode = 2; st1 = 0; st2 = 0;
        threeItems();
        runRow(11'h12A, 1'b0);
        finishRow();
        chk("stalls_applied", {32'(st1), 32'(st2)}, {32'd5, 32'd2});
        readyMode = 0;

        itemQ.delete();
        itemQ.push_back(mkItem(8'h33, 1'b1, 2'd0, 1'b0));
        runRow(11'h055, 1'b0);
        @(negedge clk);
        chk("empty_row_idle", 64'(oBusy), 64'd0);
        finishRow();

        itemQ.delete();
        for (int i = 0; i < 10; i++)
            itemQ.push_back(mkItem(8'(8'h40 + 4 * i), 1'($urandom), 2'($urandom), 1'b1));
        runRow(11'h3C1, 1'b0);
        finishRow();

        reqRow(11'h2F0);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("timeout_before", {oBusy, oTimeout}, 2'b10);
        @(negedge clk);
        chk("timeout_hit", {oBusy, oTimeout}, 2'b01);
        expT = 1'b1;
        finishRow();

        threeItems();
        runRow(11'h1B7, 1'b0);
        k = 0;
        while (nFire != 2 && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("reached_wait_ccd", 64'(nFire), 64'd2);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_mid_seq", {oRowAck, oROB_Rd, oROB_Row, oCmdValid, oCmd, oCmdRow, oCmdCol,
                              oCmdSize, oBusy, oTimeout, oOverflow}, 64'd0);
        expT = 1'b0; expO = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        itemQ.delete();
        itemQ.push_back(mkItem(8'hA1, 1'b1, 2'd3, 1'b1));
        itemQ.push_back(mkItem(8'hA2, 1'b0, 2'd0, 1'b1));
        runRow(11'h0F0, 1'b0);
        finishRow();

        readyMode = 1;
        for (int r = 0; r < 14; r++) begin
            itemQ.delete();
            nv = $urandom_range(0, 10);
            ni = $urandom_range(0, 2);
            while (nv + ni > 0) begin
                if (ni > 0 && (nv == 0 || $urandom_range(0, 2) == 0)) begin
                    itemQ.push_back(mkItem(8'($urandom), 1'($urandom), 2'($urandom), 1'b0));
                    ni--;
                end else begin
                    itemQ.push_back(mkItem(8'($urandom), 1'($urandom), 2'($urandom), 1'b1));
                    nv--;
                end
            end
            if (itemQ.size() == 0) itemQ.push_back(mkItem(8'h00, 1'b0, 2'd0, 1'b0));
            runRow(ROW_W'($urandom), 1'b1);
            finishRow();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
